// File: rtl/hpdcache_victim_sel.sv
// Victim selection with bit-PLRU / round-robin / LFSR-random policies and per-set replacement state.
// Latency: victim registered 1 cycle after sel_i; no backpressure, a new selection is accepted every cycle.
module hpdcache_victim_sel #(
  parameter int unsigned SETS      = 64,
  parameter int unsigned WAYS      = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,

  input  logic                     updt_i,
  input  logic [$clog2(SETS)-1:0]  updt_set_i,
  input  logic [WAYS-1:0]          updt_way_i,

  input  logic                     repl_i,
  input  logic [$clog2(SETS)-1:0]  repl_set_i,
  input  logic [WAYS-1:0]          repl_way_i,

  input  logic                     inval_i,
  input  logic [$clog2(SETS)-1:0]  inval_set_i,
  input  logic [WAYS-1:0]          inval_way_i,

  input  logic                     sel_i,
  input  logic [$clog2(SETS)-1:0]  sel_set_i,
  input  logic [1:0]               policy_i,
  input  logic [WAYS-1:0]          sel_dir_valid_i,
  input  logic [WAYS-1:0]          sel_dir_wback_i,
  input  logic [WAYS-1:0]          sel_dir_dirty_i,
  input  logic [WAYS-1:0]          sel_dir_fetch_i,

  output logic                     sel_valid_o,
  output logic [WAYS-1:0]          sel_victim_way_o,
  output logic                     sel_none_o
);

  localparam int unsigned SET_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam logic [WAYS-1:0] ONE = WAYS'(1);
  localparam logic [1:0] POL_RR   = 2'd1;
  localparam logic [1:0] POL_RAND = 2'd2;

  function automatic logic [WAYS-1:0] f_lowest(input logic [WAYS-1:0] x);
    return x & (~x + ONE);
  endfunction

  // First set bit of c scanning upward from start, wrapping: rotate down, take lowest, rotate back.
  function automatic logic [WAYS-1:0] f_rot_first(input logic [WAYS-1:0] c,
                                                  input logic [WAY_W-1:0] start);
    logic [2*WAYS-1:0] dbl;
    logic [WAYS-1:0]   low;
    dbl = {c, c} >> start;
    low = f_lowest(dbl[WAYS-1:0]);
    dbl = {low, low} << start;
    return dbl[2*WAYS-1:WAYS];
  endfunction

  function automatic logic [WAY_W-1:0] f_index(input logic [WAYS-1:0] oh);
    logic [WAY_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (oh[i]) idx = idx | WAY_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [WAYS-1:0] f_mru_next(input logic [WAYS-1:0] cur,
                                                 input logic hit_u, input logic hit_r,
                                                 input logic hit_i,
                                                 input logic [WAYS-1:0] u_way,
                                                 input logic [WAYS-1:0] r_way,
                                                 input logic [WAYS-1:0] i_way);
    logic [WAYS-1:0] m;
    logic [WAYS-1:0] setm;
    m    = cur;
    setm = (hit_u ? u_way : '0) | (hit_r ? r_way : '0);
    if (hit_i) m = m & ~i_way;
    m = m | setm;
    // Saturation: restart the epoch with only this cycle's accesses marked.
    if (&m) m = setm;
    return m;
  endfunction

  logic [WAYS-1:0]  r_mru    [SETS];
  logic [WAY_W-1:0] r_rr_ptr [SETS];
  logic [15:0]      r_lfsr;
  logic             r_sel_valid;
  logic [WAYS-1:0]  r_victim;
  logic             r_none;

  logic [WAYS-1:0]  w_mru_nxt [SETS];
  logic [WAY_W-1:0] w_rr_nxt;
  logic [15:0]      w_lfsr_nxt;
  logic [WAYS-1:0]  w_unused;
  logic [WAYS-1:0]  w_clean;
  logic [WAYS-1:0]  w_dirty;
  logic [WAYS-1:0]  w_class;
  logic [WAYS-1:0]  w_plru;
  logic [WAYS-1:0]  w_victim;
  logic             w_none;

  always_comb begin
    for (int s = 0; s < SETS; s++) begin
      w_mru_nxt[s] = f_mru_next(r_mru[s],
                                updt_i  && (updt_set_i  == SET_W'(s)),
                                repl_i  && (repl_set_i  == SET_W'(s)),
                                inval_i && (inval_set_i == SET_W'(s)),
                                updt_way_i, repl_way_i, inval_way_i);
    end
  end

  assign w_rr_nxt   = f_index(repl_way_i) + WAY_W'(1);
  assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  assign w_unused = ~sel_dir_fetch_i & ~sel_dir_valid_i;
  assign w_clean  = ~sel_dir_fetch_i &  sel_dir_valid_i & ~sel_dir_dirty_i;
  assign w_dirty  = ~sel_dir_fetch_i &  sel_dir_valid_i &  sel_dir_dirty_i & sel_dir_wback_i;

  always_comb begin
    w_class  = (w_clean != '0) ? w_clean : w_dirty;
    w_plru   = f_lowest(~r_mru[sel_set_i] & w_class);
    w_victim = '0;
    w_none   = (w_unused | w_clean | w_dirty) == '0;
    if (w_unused != '0) begin
      w_victim = f_lowest(w_unused);
    end else begin
      case (policy_i)
        POL_RR:   w_victim = f_rot_first(w_class, r_rr_ptr[sel_set_i]);
        POL_RAND: w_victim = f_rot_first(w_class, r_lfsr[WAY_W-1:0]);
        default:  w_victim = (w_plru != '0) ? w_plru : f_lowest(w_class);
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        r_mru[s]    <= '0;
        r_rr_ptr[s] <= '0;
      end
      r_lfsr      <= LFSR_SEED;
      r_sel_valid <= 1'b0;
      r_victim    <= '0;
      r_none      <= 1'b0;
    end else begin
      for (int s = 0; s < SETS; s++) begin
        r_mru[s] <= w_mru_nxt[s];
      end
      if (repl_i) r_rr_ptr[repl_set_i] <= w_rr_nxt;
      if (sel_i) begin
        r_lfsr   <= w_lfsr_nxt;
        r_victim <= w_victim;
        r_none   <= w_none;
      end
      r_sel_valid <= sel_i;
    end
  end

  assign sel_valid_o      = r_sel_valid;
  assign sel_victim_way_o = r_victim;
  assign sel_none_o       = r_none;

  a_updt_onehot:  assert property (@(posedge clk_i) disable iff (rst_i) updt_i  |-> $onehot(updt_way_i));
  a_repl_onehot:  assert property (@(posedge clk_i) disable iff (rst_i) repl_i  |-> $onehot(repl_way_i));
  a_inval_onehot: assert property (@(posedge clk_i) disable iff (rst_i) inval_i |-> $onehot(inval_way_i));

endmodule

// File: tb/tb_hpdcache_victim_sel.sv
// Directed bench for hpdcache_victim_sel (SETS=64, WAYS=4).
module tb_hpdcache_victim_sel;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       updt_i, repl_i, inval_i, sel_i;
  logic [5:0] updt_set_i, repl_set_i, inval_set_i, sel_set_i;
  logic [3:0] updt_way_i, repl_way_i, inval_way_i;
  logic [1:0] policy_i;
  logic [3:0] sel_dir_valid_i, sel_dir_wback_i, sel_dir_dirty_i, sel_dir_fetch_i;
  logic       sel_valid_o;
  logic [3:0] sel_victim_way_o;
  logic       sel_none_o;

  int n_pass   = 0;
  int n_checks = 0;

  hpdcache_victim_sel #(.SETS(64), .WAYS(4), .LFSR_SEED(16'hACE1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .updt_i(updt_i), .updt_set_i(updt_set_i), .updt_way_i(updt_way_i),
    .repl_i(repl_i), .repl_set_i(repl_set_i), .repl_way_i(repl_way_i),
    .inval_i(inval_i), .inval_set_i(inval_set_i), .inval_way_i(inval_way_i),
    .sel_i(sel_i), .sel_set_i(sel_set_i), .policy_i(policy_i),
    .sel_dir_valid_i(sel_dir_valid_i), .sel_dir_wback_i(sel_dir_wback_i),
    .sel_dir_dirty_i(sel_dir_dirty_i), .sel_dir_fetch_i(sel_dir_fetch_i),
    .sel_valid_o(sel_valid_o), .sel_victim_way_o(sel_victim_way_o), .sel_none_o(sel_none_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  task automatic idle();
    updt_i = 0; repl_i = 0; inval_i = 0; sel_i = 0;
    updt_set_i = 0; repl_set_i = 0; inval_set_i = 0; sel_set_i = 0;
    updt_way_i = 0; repl_way_i = 0; inval_way_i = 0; policy_i = 0;
    sel_dir_valid_i = 0; sel_dir_wback_i = 0; sel_dir_dirty_i = 0; sel_dir_fetch_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1; tick(); rst_i = 0;
  endtask

  task automatic set_sel(input logic [5:0] set, input logic [1:0] pol, input logic [3:0] vld,
                         input logic [3:0] fch, input logic [3:0] drt, input logic [3:0] wb);
    sel_i = 1; sel_set_i = set; policy_i = pol;
    sel_dir_valid_i = vld; sel_dir_fetch_i = fch; sel_dir_dirty_i = drt; sel_dir_wback_i = wb;
  endtask

  task automatic do_sel(input logic [5:0] set, input logic [1:0] pol, input logic [3:0] vld,
                        input logic [3:0] fch, input logic [3:0] drt, input logic [3:0] wb);
    set_sel(set, pol, vld, fch, drt, wb);
    tick();
    sel_i = 0;
  endtask

  task automatic do_updt(input logic [5:0] set, input logic [3:0] way);
    updt_i = 1; updt_set_i = set; updt_way_i = way;
    tick();
    updt_i = 0;
  endtask

  task automatic do_repl(input logic [5:0] set, input logic [3:0] way);
    repl_i = 1; repl_set_i = set; repl_way_i = way;
    tick();
    repl_i = 0;
  endtask

  task automatic chk_sel(input string name, input logic [3:0] exp_way, input logic exp_none);
    n_checks++;
    if (sel_valid_o !== 1'b1 || sel_victim_way_o !== exp_way || sel_none_o !== exp_none)
      $display("FAIL %s: got valid=%b way=%b none=%b, want valid=1 way=%b none=%b",
               name, sel_valid_o, sel_victim_way_o, sel_none_o, exp_way, exp_none);
    else n_pass++;
  endtask

  task automatic chk_mru(input string name, input int set, input logic [3:0] exp);
    n_checks++;
    if (dut.r_mru[set] !== exp) $display("FAIL %s: mru=%b want %b", name, dut.r_mru[set], exp);
    else n_pass++;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1;
    updt_i = 1; updt_set_i = 0; updt_way_i = 4'b0001;
    set_sel(0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();
    idle();
    n_checks++;
    if (sel_valid_o !== 1'b0 || sel_victim_way_o !== 4'b0 || sel_none_o !== 1'b0)
      $display("FAIL reset_outputs: valid=%b way=%b none=%b, want 0/0000/0",
               sel_valid_o, sel_victim_way_o, sel_none_o);
    else n_pass++;
    chk_mru("reset_strobe_ignored", 0, 4'b0000);
    n_checks++;
    if (dut.r_lfsr !== 16'hACE1) $display("FAIL reset_lfsr: lfsr=%h want ace1", dut.r_lfsr);
    else n_pass++;
    rst_i = 0;
  endtask

  task automatic test_first_sel();
    do_sel(3, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    chk_sel("first_sel", 4'b0001, 1'b0);
    tick();
    n_checks++;
    if (sel_valid_o !== 1'b0 || sel_victim_way_o !== 4'b0001)
      $display("FAIL valid_pulse_hold: valid=%b way=%b, want 0/0001", sel_valid_o, sel_victim_way_o);
    else n_pass++;
  endtask

  task automatic test_plru_sat();
    do_updt(5, 4'b0001); do_updt(5, 4'b0010); do_updt(5, 4'b0100);
    chk_mru("plru_three", 5, 4'b0111);
    do_updt(5, 4'b1000);
    chk_mru("plru_saturate", 5, 4'b1000);
    do_sel(5, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    chk_sel("plru_after_sat", 4'b0001, 1'b0);
  endtask

  task automatic test_concurrent_same();
    updt_i = 1;  updt_set_i = 7;  updt_way_i = 4'b0010;
    repl_i = 1;  repl_set_i = 7;  repl_way_i = 4'b0100;
    inval_i = 1; inval_set_i = 7; inval_way_i = 4'b0010;
    tick();
    idle();
    chk_mru("concurrent_same_set", 7, 4'b0110);
    n_checks++;
    if (dut.r_rr_ptr[7] !== 2'd3) $display("FAIL rr_ptr_set7: ptr=%0d want 3", dut.r_rr_ptr[7]);
    else n_pass++;
    do_sel(7, 0, 4'b1111, 4'b0001, 4'b0000, 4'b0000);
    chk_sel("plru_skip_mru", 4'b1000, 1'b0);
  endtask

  task automatic test_concurrent_diff();
    updt_i = 1; updt_set_i = 1; updt_way_i = 4'b0100;
    repl_i = 1; repl_set_i = 2; repl_way_i = 4'b0010;
    tick();
    idle();
    chk_mru("diff_set_updt", 1, 4'b0100);
    chk_mru("diff_set_repl", 2, 4'b0010);
    do_sel(1, 0, 4'b1111, 4'b0001, 4'b0000, 4'b0000);
    chk_sel("diff_set1_plru", 4'b0010, 1'b0);
    do_sel(2, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    chk_sel("diff_set2_rr", 4'b0100, 1'b0);
  endtask

  task automatic test_round_robin();
    do_repl(0, 4'b1000);
    do_sel(0, 1, 4'b1111, 4'b1010, 4'b0000, 4'b0000);
    chk_sel("rr_wrap", 4'b0001, 1'b0);
    do_repl(0, 4'b0001);
    do_sel(0, 1, 4'b1111, 4'b1010, 4'b0000, 4'b0000);
    chk_sel("rr_advance", 4'b0100, 1'b0);
  endtask

  task automatic test_class_priority();
    for (int p = 0; p < 4; p++) begin
      do_sel(10, 2'(p), 4'b1011, 4'b0000, 4'b0000, 4'b0000);
      chk_sel($sformatf("unused_first_pol%0d", p), 4'b0100, 1'b0);
    end
    do_sel(10, 0, 4'b1111, 4'b0000, 4'b1011, 4'b1111);
    chk_sel("clean_over_dirty", 4'b0100, 1'b0);
    do_sel(10, 0, 4'b1111, 4'b0000, 4'b1111, 4'b0110);
    chk_sel("dirty_class", 4'b0010, 1'b0);
    do_sel(10, 0, 4'b1111, 4'b0000, 4'b1111, 4'b0000);
    chk_sel("dirty_no_wback_none", 4'b0000, 1'b1);
    do_sel(10, 1, 4'b1011, 4'b1111, 4'b0000, 4'b0000);
    chk_sel("all_fetching_none", 4'b0000, 1'b1);
  endtask

  task automatic test_no_bypass();
    updt_i = 1; updt_set_i = 9; updt_way_i = 4'b0001;
    do_sel(9, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    updt_i = 0;
    chk_sel("no_bypass", 4'b0001, 1'b0);
    do_sel(9, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    chk_sel("update_visible_next", 4'b0010, 1'b0);
  endtask

  task automatic test_back_to_back_random();
    logic [15:0] m;
    logic [3:0]  rec [16];
    logic [3:0]  exp;
    int          cnt [4];
    int          errs;
    int          errs2;
    idle();
    do_reset();
    m = 16'hACE1; errs = 0; errs2 = 0;
    for (int w = 0; w < 4; w++) cnt[w] = 0;
    set_sel(12, 2, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 1000; i++) begin
      tick();
      exp = 4'b0001 << m[1:0];
      if (sel_valid_o !== 1'b1 || sel_victim_way_o !== exp) errs++;
      for (int w = 0; w < 4; w++) if (sel_victim_way_o[w]) cnt[w]++;
      if (i < 16) rec[i] = sel_victim_way_o;
      m = lfsr_step(m);
    end
    sel_i = 0;
    n_checks++;
    if (errs != 0) $display("FAIL random_sequence: %0d bad cycles, want 0", errs);
    else n_pass++;
    for (int w = 0; w < 4; w++) begin
      n_checks++;
      if (cnt[w] < 200) $display("FAIL random_spread_way%0d: count=%0d want >=200", w, cnt[w]);
      else n_pass++;
    end
    tick(); tick();
    n_checks++;
    if (sel_valid_o !== 1'b0 || dut.r_lfsr !== m)
      $display("FAIL lfsr_hold: valid=%b lfsr=%h, want 0/%h", sel_valid_o, dut.r_lfsr, m);
    else n_pass++;
    set_sel(12, 2, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    tick();
    rst_i = 1;
    tick();
    rst_i = 0;
    n_checks++;
    if (sel_valid_o !== 1'b0) $display("FAIL reset_discards_sel: valid=%b want 0", sel_valid_o);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (sel_valid_o !== 1'b1 || sel_victim_way_o !== rec[i]) errs2++;
    end
    sel_i = 0;
    n_checks++;
    if (errs2 != 0) $display("FAIL random_replay: %0d differing cycles, want 0", errs2);
    else n_pass++;
  endtask

  initial begin
    idle();
    rst_i = 1;
    test_reset();
    test_first_sel();
    test_plru_sat();
    test_concurrent_same();
    test_concurrent_diff();
    test_round_robin();
    test_class_priority();
    test_no_bypass();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hpdcache_victim_sel.md
# hpdcache_victim_sel

Next-generation victim selection and replacement-state block for the HPDcache. It supports three run-time replacement policies (bit-PLRU, per-set round-robin, LFSR pseudo-random) and registers the victim one cycle after the request. Access updates, refills and invalidations to different sets commit in the same cycle. It sits beside the cache directory and is driven by the miss handler (selection, refill) and the core pipeline (hits, invalidations).

## Interface
- SETS, 64: number of sets; power of two, ≥2.
- WAYS, 4: number of ways; power of two, 2..32.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be non-zero.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; synchronous and active-high.
- updt_i / updt_set_i / updt_way_i  in  1 / log2(SETS) / WAYS  access (hit) update; way one-hot.
- repl_i / repl_set_i / repl_way_i  in  1 / log2(SETS) / WAYS  refill commit; way one-hot.
- inval_i / inval_set_i / inval_way_i  in  1 / log2(SETS) / WAYS  line invalidation; way one-hot.
- sel_i  in  1  victim selection request.
- sel_set_i  in  log2(SETS)  set to select in.
- policy_i  in  2  0=bit-PLRU, 1=round-robin, 2=random, 3=reserved (behaves as 0).
- sel_dir_valid_i, sel_dir_wback_i, sel_dir_dirty_i, sel_dir_fetch_i  in  WAYS each  directory state of sel_set_i.
- sel_valid_o  out  1  victim result valid, one cycle after sel_i.
- sel_victim_way_o  out  WAYS  one-hot victim; 0 when none.
- sel_none_o  out  1  no eligible way; qualified by sel_valid_o.

## Operation
- State per set:
  - mru[WAYS] bits.
  - rr_ptr[log2(WAYS)] pointer.
- Global state: 16-bit Fibonacci LFSR, taps 16,14,13,11.
- Eligibility classes, with f = ~fetch and v = valid:
  - unused = f & ~v.
  - clean = f & v & ~dirty.
  - dirty = f & v & dirty & wback.
- Class priority: unused > clean > dirty. If all classes are empty, the victim is 0 and sel_none_o=1.
- Unused class: always the lowest-index unused way, in every policy.
- Clean/dirty class, picking within class C:
  - PLRU: lowest index of ~mru & C. If that is empty, fall back to the lowest index of C. The victim is never 0 while C is non-empty.
  - RR: first way of C scanning upward from rr_ptr[sel_set_i], wrapping modulo WAYS.
  - Random: same rotating scan, starting at lfsr[log2(WAYS)-1:0].
- LFSR advances one step on every cycle where sel_i=1. It holds otherwise.
- mru update per set s, per cycle, applied in this order:
  1. Clear bits from inval_way_i if inval_i and inval_set_i==s.
  2. OR in updt_way_i (if updt_i, set matches) and repl_way_i (if repl_i, set matches).
  3. If the result is all-ones, replace it with (updt_way_i|repl_way_i) masked to the matching sources.
- Update/invalidation conflicts: when inval and updt/repl target the same set and way, the set wins.
- rr_ptr update: on repl_i, rr_ptr[repl_set_i] = (index(repl_way_i)+1) mod WAYS. updt_i and inval_i do not move it.
- Policy changes take effect on the next sel_i. State is not cleared.
- State is maintained for all policies regardless of policy_i.
- Input assumptions: updt_way_i, repl_way_i and inval_way_i are one-hot when their strobe is asserted. Behaviour with non-one-hot values is undefined, and an assertion flags it.

## Timing
- Selection latency is 1 cycle. sel_i at edge N gives sel_valid_o, sel_victim_way_o and sel_none_o at N+1.
- Outputs hold until the next sel_i; sel_valid_o is a 1-cycle pulse.
- Selection reads state as registered before edge N. There is no bypass of updates issued in the same cycle as sel_i.
- Back-to-back sel_i every cycle is supported at full throughput.
- Updates commit at the clock edge of their strobe cycle and are visible to a sel_i in the following cycle.
- Reset values: all mru=0, all rr_ptr=0, lfsr=LFSR_SEED, sel_valid_o=0, sel_victim_way_o=0, sel_none_o=0.
- Reset asserted mid-operation:
  - Discards any pending selection; sel_valid_o=0 in the cycle after rst_i.
  - Strobes in the reset cycle are ignored.

## Test plan
- Reset, then WAYS=4, policy=0, sel_i set 3 with valid=4'b1111, dirty=0. Expect sel_valid_o=1 next cycle, victim 4'b0001.
- PLRU saturation: updt set 5 ways 0,1,2 on consecutive cycles, then updt way 3. Expect mru[5]=4'b1000. A following sel (all clean) returns 4'b0001.
- Concurrent events, same set 7: updt way 1 + repl way 2 + inval way 1. Expect mru[7]=4'b0110.
- Concurrent events, different sets: updt set 1 and repl set 2 in the same cycle. Expect both sets updated.
- Round-robin: repl set 0 way 3, then sel set 0 with clean={0,2}. Expect victim 4'b0001. Then repl way 0, sel again: expect 4'b0100.
- Class priority: valid=4'b1011, fetch=4'b0000. Expect victim 4'b0100 under every policy. Next, fetch=all-ones: expect sel_none_o=1 and victim 0.
- Random: 1000 sel_i with all ways clean, policy=2. Every way is chosen at least 200 times. After reset the sequence repeats identically from LFSR_SEED.
